// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin / fixed-select N:1 multiplexer.
package mux_pkg;

  // Arbitration mode driven on the mode port.
  typedef enum logic {
    MODE_RR    = 1'b0,
    MODE_FIXED = 1'b1
  } mode_e;

  localparam int unsigned DEF_NUM_CH = 4;
  localparam int unsigned DEF_DATA_W = 8;

  // Index width for n channels; never below one bit.
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: one-hot grant to the first requester after ptr.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned IDX_W  = idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  input  logic              en,
  output logic [NUM_CH-1:0] grant
);

  logic             found;
  logic [IDX_W-1:0] pos;

  // Search ptr+1, ptr+2, ... wrapping, and grant the first active request.
  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      pos = IDX_W'((32'(ptr) + k) % NUM_CH);
      if (en && !found && req[pos]) begin
        grant[pos] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_nto1.sv
// N:1 valid/ready multiplexer with a registered output stage.
// Mode 0 arbitrates round-robin, mode 1 forwards only channel sel.
// Optional packet locking: define MUX_RR_PKT_LOCK_EN to add in_last/out_last
// and hold the grant on one channel until its last beat is accepted.
module mux_rr_nto1
  import mux_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH*DATA_W-1:0]   in_data,
  input  logic [NUM_CH-1:0]          in_valid,
  output logic [NUM_CH-1:0]          in_ready,
`ifdef MUX_RR_PKT_LOCK_EN
  input  logic [NUM_CH-1:0]          in_last,
  output logic                       out_last,
`endif
  input  logic                       mode,
  input  logic [idx_w(NUM_CH)-1:0]   sel,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int unsigned IDX_W = idx_w(NUM_CH);

  logic [IDX_W-1:0]  ptr;
  logic [NUM_CH-1:0] req_c;
  logic [NUM_CH-1:0] grant_c;
  logic              can_load_c;
  logic              arb_en_c;
  logic              accept_c;
  logic [IDX_W-1:0]  gidx_c;
  logic [DATA_W-1:0] gdata_c;
  mode_e             mode_eff_c;

`ifdef MUX_RR_PKT_LOCK_EN
  logic              locked;
  logic [IDX_W-1:0]  lock_ch;
  mode_e             lock_mode;
  logic              glast_c;
`endif

  // Build the request vector seen by the arbiter from mode, sel and lock state.
  always_comb begin
    mode_eff_c = mode_e'(mode);
    req_c      = '0;
`ifdef MUX_RR_PKT_LOCK_EN
    if (locked) begin
      mode_eff_c = lock_mode;
    end
`endif
    if (NUM_CH == 1) begin
      req_c = in_valid;
`ifdef MUX_RR_PKT_LOCK_EN
    end else if (locked) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (lock_ch == IDX_W'(i)) req_c[i] = in_valid[i];
      end
`endif
    end else if (mode_eff_c == MODE_RR) begin
      req_c = in_valid;
    end else begin
      // Out-of-range sel matches no channel, so nothing is granted.
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (sel == IDX_W'(i)) req_c[i] = in_valid[i];
      end
    end
  end

  assign can_load_c = !out_valid || out_ready;
  assign arb_en_c   = can_load_c && !rst;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req   (req_c),
    .ptr   (ptr),
    .en    (arb_en_c),
    .grant (grant_c)
  );

  assign in_ready = grant_c;
  assign accept_c = |grant_c;

  // Decode the one-hot grant into an index and the selected channel's data.
  always_comb begin
    gidx_c  = '0;
    gdata_c = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (grant_c[i]) begin
        gidx_c  = IDX_W'(i);
        gdata_c = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef MUX_RR_PKT_LOCK_EN
  assign glast_c = |(grant_c & in_last);
`endif

  // Output register and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      ptr       <= IDX_W'(NUM_CH - 1);
    end else if (accept_c) begin
      out_valid <= 1'b1;
      out_data  <= gdata_c;
      if (mode_eff_c == MODE_RR) ptr <= gidx_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUX_RR_PKT_LOCK_EN
  // Packet lock: latch channel and mode on a non-last beat, release on last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked    <= 1'b0;
      lock_ch   <= '0;
      lock_mode <= MODE_RR;
      out_last  <= 1'b0;
    end else if (accept_c) begin
      locked    <= !glast_c;
      lock_ch   <= gidx_c;
      lock_mode <= mode_eff_c;
      out_last  <= glast_c;
    end
  end
`endif

endmodule

// File: tb/tb_mux_rr_nto1.sv
// Directed self-checking bench for mux_rr_nto1 (4-channel main DUT plus a
// 5-channel instance to reach sel values beyond the channel count).
module tb_mux_rr_nto1;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  logic [39:0] in_data5;
  logic [4:0]  in_valid5;
  logic [4:0]  in_ready5;
  logic        mode5;
  logic [2:0]  sel5;
  logic [7:0]  out_data5;
  logic        out_valid5;
  logic        out_ready5;

`ifdef MUX_RR_PKT_LOCK_EN
  logic [3:0]  in_last;
  logic        out_last;
  logic [4:0]  in_last5;
  logic        out_last5;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mux_rr_nto1 #(.NUM_CH(4), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef MUX_RR_PKT_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  mux_rr_nto1 #(.NUM_CH(5), .DATA_W(8)) dut5 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data5),
    .in_valid  (in_valid5),
    .in_ready  (in_ready5),
`ifdef MUX_RR_PKT_LOCK_EN
    .in_last   (in_last5),
    .out_last  (out_last5),
`endif
    .mode      (mode5),
    .sel       (sel5),
    .out_data  (out_data5),
    .out_valid (out_valid5),
    .out_ready (out_ready5)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; in_valid = 4'hF; out_ready = 1'b1; mode = 1'b0; sel = 2'd0;
    @(negedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %h exp 00", out_data); end
    n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready got %b exp 0000", in_ready); end
    in_valid = 4'h0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // All channels valid: order 0,1,2,3,0,... one beat per cycle.
  task automatic test_rr_all();
    logic [3:0] exp_rdy;
    logic [7:0] exp_dat;
    in_valid = 4'hF; out_ready = 1'b1; mode = 1'b0;
    #1;
    n_checks++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL rr_first_grant got %b exp 0001", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rr_pre_valid got %b exp 0", out_valid); end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); #1;
      exp_dat = 8'(8'hA0 + (k - 1) % 4);
      exp_rdy = 4'(1 << (k % 4));
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid[%0d] got %b exp 1", k, out_valid); end
      n_checks++; if (out_data !== exp_dat) begin n_fail++; $display("FAIL rr_data[%0d] got %h exp %h", k, out_data, exp_dat); end
      n_checks++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_ready[%0d] got %b exp %b", k, in_ready, exp_rdy); end
    end
    in_valid = 4'h0;
    @(negedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drain got %b exp 0", out_valid); end
  endtask

  // Channels 0 and 2 only: strict alternation, odd channels never ready.
  task automatic test_alternate();
    logic [3:0] exp_rdy;
    logic [7:0] exp_dat;
    in_valid = 4'b0101;
    #1;
    n_checks++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL alt_first got %b exp 0001", in_ready); end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk); #1;
      exp_dat = ((k - 1) % 2 == 0) ? 8'hA0 : 8'hA2;
      exp_rdy = (k % 2 == 0) ? 4'b0001 : 4'b0100;
      n_checks++; if (out_data !== exp_dat) begin n_fail++; $display("FAIL alt_data[%0d] got %h exp %h", k, out_data, exp_dat); end
      n_checks++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL alt_ready[%0d] got %b exp %b", k, in_ready, exp_rdy); end
    end
    in_valid = 4'h0;
    @(negedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL alt_drain got %b exp 0", out_valid); end
  endtask

  // Downstream stall for 5 cycles with a beat held.
  task automatic test_backpressure();
    in_valid = 4'hF; out_ready = 1'b0;
    #1;
    n_checks++; if (in_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_grant got %b exp 1000", in_ready); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %b exp 1", k, out_valid); end
      n_checks++; if (out_data !== 8'hA3) begin n_fail++; $display("FAIL bp_data[%0d] got %h exp a3", k, out_data); end
      n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready[%0d] got %b exp 0000", k, in_ready); end
    end
    in_valid = 4'h0; out_ready = 1'b1;
    #1;
    n_checks++; if (out_data !== 8'hA3 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_release got %b/%h exp 1/a3", out_valid, out_data); end
    @(negedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_emitted got %b exp 0", out_valid); end
  endtask

  // Fixed select on channel 2; afterwards the round-robin pointer is untouched.
  task automatic test_fixed();
    mode = 1'b1; sel = 2'd2; in_valid = 4'hF;
    #1;
    n_checks++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL fix_first got %b exp 0100", in_ready); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); #1;
      n_checks++; if (out_data !== 8'hA2) begin n_fail++; $display("FAIL fix_data[%0d] got %h exp a2", k, out_data); end
      n_checks++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL fix_ready[%0d] got %b exp 0100", k, in_ready); end
    end
    mode = 1'b0;
    #1;
    n_checks++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL fix_ptr_kept got %b exp 0001", in_ready); end
    in_valid = 4'h0;
    @(negedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fix_drain got %b exp 0", out_valid); end
  endtask

  // Five-channel instance: sel=2 beat, then sel=5 grants nothing and drains.
  task automatic test_sel_oob();
    mode5 = 1'b1; sel5 = 3'd2; in_valid5 = 5'h1F; out_ready5 = 1'b1;
    #1;
    n_checks++; if (in_ready5 !== 5'b00100) begin n_fail++; $display("FAIL oob_sel2 got %b exp 00100", in_ready5); end
    @(negedge clk);
    sel5 = 3'd5;
    #1;
    n_checks++; if (in_ready5 !== 5'b00000) begin n_fail++; $display("FAIL oob_ready got %b exp 00000", in_ready5); end
    n_checks++; if (out_valid5 !== 1'b1 || out_data5 !== 8'hB2) begin n_fail++; $display("FAIL oob_held got %b/%h exp 1/b2", out_valid5, out_data5); end
    @(negedge clk); #1;
    n_checks++; if (out_valid5 !== 1'b0) begin n_fail++; $display("FAIL oob_drain got %b exp 0", out_valid5); end
    n_checks++; if (in_ready5 !== 5'b00000) begin n_fail++; $display("FAIL oob_ready2 got %b exp 00000", in_ready5); end
    in_valid5 = 5'h0;
  endtask

  // Reset while a beat is held: beat discarded, pointer restarts at channel 0.
  task automatic test_reset_mid();
    in_valid = 4'b0100; out_ready = 1'b0; mode = 1'b0;
    #1;
    n_checks++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL rm_grant got %b exp 0100", in_ready); end
    @(negedge clk); #1;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'hA2) begin n_fail++; $display("FAIL rm_held got %b/%h exp 1/a2", out_valid, out_data); end
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid got %b exp 0", out_valid); end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL rm_data got %h exp 00", out_data); end
    n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL rm_ready got %b exp 0000", in_ready); end
    in_valid = 4'hF; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL rm_first got %b exp 0001", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_no_emit got %b exp 0", out_valid); end
    @(negedge clk); #1;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'hA0) begin n_fail++; $display("FAIL rm_after got %b/%h exp 1/a0", out_valid, out_data); end
    in_valid = 4'h0;
    @(negedge clk);
  endtask

`ifdef MUX_RR_PKT_LOCK_EN
  // Three-beat packet on channel 1 while channel 0 also requests.
  task automatic test_pkt_lock();
    in_valid = 4'b0011; in_last = 4'b0000; out_ready = 1'b1; mode = 1'b0;
    #1;
    n_checks++; if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL pl_first got %b exp 0010", in_ready); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 2) in_last = 4'b0010;
      #1;
      n_checks++; if (out_data !== 8'hA1) begin n_fail++; $display("FAIL pl_data[%0d] got %h exp a1", k, out_data); end
      n_checks++; if (out_last !== (k == 3)) begin n_fail++; $display("FAIL pl_last[%0d] got %b exp %b", k, out_last, (k == 3)); end
      if (k < 3) begin
        n_checks++; if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL pl_hold[%0d] got %b exp 0010", k, in_ready); end
      end else begin
        n_checks++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL pl_release got %b exp 0001", in_ready); end
      end
    end
    in_valid = 4'h0; in_last = 4'h0;
    @(negedge clk);
  endtask
`endif

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) in_data[i*8 +: 8] = 8'(8'hA0 + i);
    for (int i = 0; i < 5; i++) in_data5[i*8 +: 8] = 8'(8'hB0 + i);
    in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b1;
    in_valid5 = '0; mode5 = 1'b0; sel5 = '0; out_ready5 = 1'b1;
`ifdef MUX_RR_PKT_LOCK_EN
    in_last = '0; in_last5 = '0;
`endif
    test_reset();
    test_rr_all();
    test_alternate();
    test_backpressure();
    test_fixed();
    test_sel_oob();
    test_reset_mid();
`ifdef MUX_RR_PKT_LOCK_EN
    test_pkt_lock();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
